// File: rtl/bitstream_carry_resolver.sv
`default_nettype none
// ============================================================================
// Module      : bitstream_carry_resolver
// Description : Carry-propagation and byte-serialisation stage behind the
//               three-lane arithmetic encoder. Each accepted beat carries up
//               to six pre-bitstream words: a byte in [7:0] and a carry into
//               earlier bytes in [8]. Carries are resolved against a held
//               pending byte plus a counted run of 0xFF bytes. Final bytes
//               leave one per cycle over a valid/ready interface.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   general_clk            clock
//   reset                  synchronous, active-high reset
//   in_valid / in_ready    input beat handshake (in_ready only while idle)
//   in_flag_1..3           per-lane word count (0, 1, 2; 3 acts as 2 + err)
//   in_bit_1_1..in_bit_3_2 six pre-bitstream words, lane-major
//   in_flush               end of frame, qualified by the beat handshake
//   out_byte / out_valid   resolved byte and its valid
//   out_ready              downstream accepts the byte
//   out_last               final byte of a frame
//   done                   one-cycle pulse when a flush completes
//   err                    sticky error flag, cleared only by reset
//   out_byte_count         handshaken output byte count (optional)
// Build option:
//   BITSTREAM_BYTE_COUNT_EN adds the out_byte_count port and its counter.
// ============================================================================
module bitstream_carry_resolver #(
    parameter int GENERAL_RANGE_WIDTH = 16,
    parameter int RUN_WIDTH           = 16
) (
    input  logic                           general_clk,
    input  logic                           reset,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [1:0]                     in_flag_1,
    input  logic [1:0]                     in_flag_2,
    input  logic [1:0]                     in_flag_3,
    input  logic [GENERAL_RANGE_WIDTH-1:0] in_bit_1_1,
    input  logic [GENERAL_RANGE_WIDTH-1:0] in_bit_1_2,
    input  logic [GENERAL_RANGE_WIDTH-1:0] in_bit_2_1,
    input  logic [GENERAL_RANGE_WIDTH-1:0] in_bit_2_2,
    input  logic [GENERAL_RANGE_WIDTH-1:0] in_bit_3_1,
    input  logic [GENERAL_RANGE_WIDTH-1:0] in_bit_3_2,
    input  logic                           in_flush,
    output logic [7:0]                     out_byte,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic                           out_last,
    output logic                           done,
    output logic                           err
`ifdef BITSTREAM_BYTE_COUNT_EN
    ,
    output logic [31:0]                    out_byte_count
`endif
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_WORD      = 3'd1;
    localparam logic [2:0] S_EMIT_P    = 3'd2;
    localparam logic [2:0] S_EMIT_RUN  = 3'd3;
    localparam logic [2:0] S_FLUSH_P   = 3'd4;
    localparam logic [2:0] S_FLUSH_RUN = 3'd5;
    localparam logic [2:0] S_DONE      = 3'd6;

    localparam logic [RUN_WIDTH-1:0] c_run_max = {RUN_WIDTH{1'b1}};
    localparam logic [RUN_WIDTH-1:0] c_run_one = RUN_WIDTH'(1);

    logic [2:0]                     r_state;
    logic [GENERAL_RANGE_WIDTH-1:0] r_words [0:5];
    logic [5:0]                     r_mask;      // words of the beat still to process
    logic                           r_flush;
    logic [7:0]                     r_pend;      // pending byte P
    logic                           r_has_p;
    logic [RUN_WIDTH-1:0]           r_run;       // count R of held 0xFF bytes
    logic [RUN_WIDTH-1:0]           r_emit_cnt;  // run bytes still to present
    logic [7:0]                     r_fill;      // 0x00 after a carry, else 0xFF
    logic [7:0]                     r_out_byte;
    logic                           r_out_valid;
    logic                           r_out_last;
    logic                           r_done;
    logic                           r_err;

    logic [2:0]                     w_sel;
    logic                           w_any;
    logic [5:0]                     w_sel_oh;
    logic [GENERAL_RANGE_WIDTH-1:0] w_word;
    logic                           w_carry;
    logic [7:0]                     w_byte;
    logic                           w_hi_err;
    logic                           w_bad_flag;

    // Flag 3 is treated as a two-word lane.
    function automatic logic [1:0] f_lane_mask(input logic [1:0] flag);
        case (flag)
            2'd0:    f_lane_mask = 2'b00;
            2'd1:    f_lane_mask = 2'b01;
            default: f_lane_mask = 2'b11;
        endcase
    endfunction

    // Lowest outstanding word in fixed order 1_1, 1_2, 2_1, 2_2, 3_1, 3_2.
    always_comb begin
        w_sel = 3'd0;
        w_any = 1'b0;
        for (int i = 5; i >= 0; i--) begin
            if (r_mask[i]) begin
                w_sel = 3'(i);
                w_any = 1'b1;
            end
        end
    end

    assign w_sel_oh   = 6'b000001 << w_sel;
    assign w_word     = r_words[w_sel];
    assign w_carry    = w_word[8];
    assign w_byte     = w_word[7:0];
    assign w_hi_err   = |(w_word >> 9);
    assign w_bad_flag = (in_flag_1 == 2'd3) || (in_flag_2 == 2'd3) || (in_flag_3 == 2'd3);

    assign in_ready  = (r_state == S_IDLE) && !reset;
    assign out_byte  = r_out_byte;
    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;
    assign done      = r_done;
    assign err       = r_err;

    // Beat payload; only meaningful while the mask says so, so no reset.
    always_ff @(posedge general_clk) begin
        if (in_valid && in_ready) begin
            r_words[0] <= in_bit_1_1;
            r_words[1] <= in_bit_1_2;
            r_words[2] <= in_bit_2_1;
            r_words[3] <= in_bit_2_2;
            r_words[4] <= in_bit_3_1;
            r_words[5] <= in_bit_3_2;
        end
    end

    always_ff @(posedge general_clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_mask      <= 6'd0;
            r_flush     <= 1'b0;
            r_pend      <= 8'h00;
            r_has_p     <= 1'b0;
            r_run       <= '0;
            r_emit_cnt  <= '0;
            r_fill      <= 8'h00;
            r_out_byte  <= 8'h00;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_mask  <= {f_lane_mask(in_flag_3), f_lane_mask(in_flag_2),
                                    f_lane_mask(in_flag_1)};
                        r_flush <= in_flush;
                        if (w_bad_flag) r_err <= 1'b1;
                        r_state <= S_WORD;
                    end
                end

                S_WORD: begin
                    if (w_any) begin
                        r_mask <= r_mask & ~w_sel_oh;
                        if (w_hi_err) r_err <= 1'b1;
                        if (!r_has_p) begin
                            // Nothing to carry into: the carry is dropped.
                            r_pend  <= w_byte;
                            r_has_p <= 1'b1;
                            if (w_carry) r_err <= 1'b1;
                        end else if (w_carry) begin
                            // Carry ripples through the run: P+1 then zeros.
                            r_out_byte  <= r_pend + 8'd1;
                            r_out_valid <= 1'b1;
                            r_fill      <= 8'h00;
                            r_emit_cnt  <= r_run;
                            r_pend      <= w_byte;
                            r_run       <= '0;
                            r_state     <= S_EMIT_P;
                        end else if (w_byte == 8'hFF) begin
                            // A 0xFF might still receive a carry: hold it.
                            if (r_run == c_run_max) r_err <= 1'b1;
                            else                    r_run <= r_run + c_run_one;
                        end else begin
                            // A non-0xFF byte absorbs any future carry, so
                            // everything held before it is final.
                            r_out_byte  <= r_pend;
                            r_out_valid <= 1'b1;
                            r_fill      <= 8'hFF;
                            r_emit_cnt  <= r_run;
                            r_pend      <= w_byte;
                            r_run       <= '0;
                            r_state     <= S_EMIT_P;
                        end
                    end else if (r_flush) begin
                        if (r_has_p) begin
                            r_out_byte  <= r_pend;
                            r_out_valid <= 1'b1;
                            r_out_last  <= (r_run == '0);
                            r_emit_cnt  <= r_run;
                            r_state     <= S_FLUSH_P;
                        end else begin
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end
                    end else begin
                        r_state <= S_IDLE;
                    end
                end

                S_EMIT_P, S_EMIT_RUN: begin
                    if (out_ready) begin
                        if (r_emit_cnt != '0) begin
                            r_out_byte <= r_fill;
                            r_emit_cnt <= r_emit_cnt - c_run_one;
                            r_state    <= S_EMIT_RUN;
                        end else begin
                            r_out_valid <= 1'b0;
                            r_state     <= S_WORD;
                        end
                    end
                end

                S_FLUSH_P, S_FLUSH_RUN: begin
                    if (out_ready) begin
                        if (r_emit_cnt != '0) begin
                            r_out_byte <= 8'hFF;
                            r_out_last <= (r_emit_cnt == c_run_one);
                            r_emit_cnt <= r_emit_cnt - c_run_one;
                            r_state    <= S_FLUSH_RUN;
                        end else begin
                            r_out_valid <= 1'b0;
                            r_out_last  <= 1'b0;
                            r_done      <= 1'b1;
                            r_state     <= S_DONE;
                        end
                    end
                end

                S_DONE: begin
                    r_has_p <= 1'b0;
                    r_run   <= '0;
                    r_flush <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef BITSTREAM_BYTE_COUNT_EN
    logic [31:0] r_byte_count;

    always_ff @(posedge general_clk) begin
        if (reset || r_done) begin
            r_byte_count <= 32'd0;
        end else if (r_out_valid && out_ready) begin
            r_byte_count <= r_byte_count + 32'd1;
        end
    end

    assign out_byte_count = r_byte_count;
`endif

endmodule
`default_nettype wire
